// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding and a ceil-log2 helper.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_DEV_ADDR   = 4'd1,
    ST_DEV_ACK    = 4'd2,
    ST_REG_ADDR   = 4'd3,
    ST_REG_ACK    = 4'd4,
    ST_WDATA      = 4'd5,
    ST_WDATA_ACK  = 4'd6,
    ST_RDATA      = 4'd7,
    ST_RDATA_MACK = 4'd8,
    ST_IGNORE     = 4'd9
  } state_t;

  function automatic int unsigned clogb2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes scl/sda into clk and derives registered edge and START/STOP pulses.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);

  // [0],[1] form the synchronizer, [2] is the history flop
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q     <= 3'b111;
      sda_q     <= 3'b111;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      sda_s     <= 1'b1;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      scl_q     <= {scl_q[1:0], scl};
      sda_q     <= {sda_q[1:0], sda};
      scl_rise  <= scl_q[1] & ~scl_q[2];
      scl_fall  <= ~scl_q[1] & scl_q[2];
      sda_s     <= sda_q[1];
      start_det <= scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
      stop_det  <= scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
    end
  end

endmodule

// File: rtl/i2c_slave.sv
// I2C target bridging register-address-framed bus transfers to a word-wide register file.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [6:0]  SLAVE_ADDR = 7'h50
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scl,
  inout  wire                   sda,
  output logic                  wr_en,
  output logic [7:0]            wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_req,
  output logic [7:0]            rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy
);

  localparam int unsigned NB  = DATA_WIDTH / 8;
  localparam int unsigned BCW = (NB > 1) ? clogb2(NB) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NB - 1);

  logic scl_rise, scl_fall, sda_s, start_det, stop_det;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl       (scl),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .sda_s     (sda_s),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t                state;
  logic [2:0]            bit_cnt;
  logic [BCW-1:0]        byte_cnt;
  logic [DATA_WIDTH-1:0] sh;
  logic [7:0]            reg_addr;
  logic                  rw, ack, mack, wr_full, sda_oe;
  logic [7:0]            rx_byte;

  assign sda     = sda_oe ? 1'b0 : 1'bz;
  assign rx_byte = {sh[6:0], sda_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= 3'd0;
      byte_cnt <= '0;
      sh       <= '0;
      reg_addr <= 8'd0;
      rw       <= 1'b0;
      ack      <= 1'b0;
      mack     <= 1'b1;
      wr_full  <= 1'b0;
      sda_oe   <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= 8'd0;
      wr_data  <= '0;
      rd_req   <= 1'b0;
      rd_addr  <= 8'd0;
      busy     <= 1'b0;
    end else begin
      wr_en  <= 1'b0;
      rd_req <= 1'b0;
      if (start_det) begin
        state    <= ST_DEV_ADDR;
        bit_cnt  <= 3'd0;
        byte_cnt <= '0;
        wr_full  <= 1'b0;
        sda_oe   <= 1'b0;
      end else if (stop_det) begin
        state  <= ST_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          ST_DEV_ADDR: if (scl_rise) begin
            sh      <= {sh[DATA_WIDTH-2:0], sda_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (rx_byte[7:1] == SLAVE_ADDR) begin
                state  <= ST_DEV_ACK;
                rw     <= rx_byte[0];
                rd_req <= rx_byte[0];
                ack    <= 1'b1;
                busy   <= 1'b1;
              end else begin
                state <= ST_IGNORE;
                busy  <= 1'b0;
              end
            end
          end
          ST_REG_ADDR: if (scl_rise) begin
            sh      <= {sh[DATA_WIDTH-2:0], sda_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              reg_addr <= rx_byte;
              rd_addr  <= rx_byte;
              ack      <= 1'b1;
              state    <= ST_REG_ACK;
            end
          end
          ST_WDATA: if (scl_rise) begin
            sh      <= {sh[DATA_WIDTH-2:0], sda_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= ST_WDATA_ACK;
              ack   <= ~wr_full;
              if (!wr_full) begin
                if (byte_cnt == LAST_BYTE) begin
                  wr_en   <= 1'b1;
                  wr_data <= {sh[DATA_WIDTH-2:0], sda_s};
                  wr_addr <= reg_addr;
                  wr_full <= 1'b1;
                end else begin
                  byte_cnt <= byte_cnt + BCW'(1);
                end
              end
            end
          end
          // bit_cnt doubles as the phase: first fall drives the ACK, second ends the slot
          ST_DEV_ACK, ST_REG_ACK, ST_WDATA_ACK: if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              sda_oe  <= ack;
              bit_cnt <= 3'd1;
            end else begin
              bit_cnt <= 3'd0;
              sda_oe  <= 1'b0;
              if (state == ST_DEV_ACK && rw) begin
                state  <= ST_RDATA;
                sda_oe <= ~sh[DATA_WIDTH-1];
              end else if (state == ST_DEV_ACK) begin
                state <= ST_REG_ADDR;
              end else begin
                state <= ST_WDATA;
              end
            end
          end
          // ones shift in behind the data so reads past the word release the bus
          ST_RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= ST_RDATA_MACK;
            end
            if (scl_fall) begin
              sh     <= {sh[DATA_WIDTH-2:0], 1'b1};
              sda_oe <= ~sh[DATA_WIDTH-2];
            end
          end
          ST_RDATA_MACK: begin
            if (scl_rise) mack <= sda_s;
            if (scl_fall) begin
              if (bit_cnt == 3'd0) begin
                sh      <= {sh[DATA_WIDTH-2:0], 1'b1};
                sda_oe  <= 1'b0;
                bit_cnt <= 3'd1;
              end else begin
                bit_cnt <= 3'd0;
                if (!mack) begin
                  state  <= ST_RDATA;
                  sda_oe <= ~sh[DATA_WIDTH-1];
                  if (byte_cnt != LAST_BYTE) byte_cnt <= byte_cnt + BCW'(1);
                end else begin
                  state  <= ST_IGNORE;
                  sda_oe <= 1'b0;
                end
              end
            end
          end
          default: sda_oe <= 1'b0;
        endcase
      end
      if (rd_req) sh <= rd_data;
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: table of write transactions plus read and reset sequences.
module tb_i2c_slave;

  localparam int Q = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        m_sda = 1'b1;
  wire         sda_bus;
  logic        wr_en, rd_req, busy;
  logic [7:0]  wr_addr, rd_addr;
  logic [31:0] wr_data, rd_data;

  assign sda_bus = m_sda ? 1'bz : 1'b0;
  pullup (sda_bus);

  i2c_slave #(.DATA_WIDTH(32), .SLAVE_ADDR(7'h50)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .scl     (scl),
    .sda     (sda_bus),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_req  (rd_req),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int          wr_cnt = 0, rd_cnt = 0, busy_cyc = 0, drv_cyc = 0;
  logic [7:0]  wr_addr_seen = 8'd0, rd_addr_seen = 8'd0;
  logic [31:0] wr_data_seen = 32'd0;

  always @(negedge clk) begin
    if (wr_en) begin
      wr_cnt       <= wr_cnt + 1;
      wr_addr_seen <= wr_addr;
      wr_data_seen <= wr_data;
    end
    if (rd_req) begin
      rd_cnt       <= rd_cnt + 1;
      rd_addr_seen <= rd_addr;
    end
    if (busy) busy_cyc <= busy_cyc + 1;
    if (m_sda && sda_bus === 1'b0) drv_cyc <= drv_cyc + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bit_io(input logic b, output logic rb);
    m_sda = b;
    #Q scl = 1'b1;
    #Q rb = (sda_bus === 1'b0) ? 1'b0 : 1'b1;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_start;
    m_sda = 1'b1;
    #Q scl = 1'b1;
    #Q m_sda = 1'b0;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop;
    m_sda = 1'b0;
    #Q scl = 1'b1;
    #Q m_sda = 1'b1;
    #(2*Q);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic acked);
    logic rb;
    for (int i = 7; i >= 0; i--) bit_io(b[i], rb);
    bit_io(1'b1, rb);
    acked = ~rb;
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] b);
    logic rb;
    b = 8'd0;
    for (int i = 0; i < 8; i++) begin
      bit_io(1'b1, rb);
      b = {b[6:0], rb};
    end
    bit_io(nack, rb);
  endtask

  typedef struct {
    logic [6:0]  dev;
    logic [7:0]  ra;
    logic [31:0] data;
    logic [7:0]  extra;
    int          nb;
    logic [7:0]  exp_ack;
    int          exp_wr;
    logic        exp_busy;
  } vec_t;

  vec_t vecs [5];

  task automatic run_write(input vec_t v, input int idx);
    int w0, r0, b0, d0;
    logic [7:0] acks, db;
    logic a;
    w0 = wr_cnt; r0 = rd_cnt; b0 = busy_cyc; d0 = drv_cyc;
    acks = 8'd0;
    i2c_start;
    wr_byte({v.dev, 1'b0}, a); acks = {acks[6:0], a};
    wr_byte(v.ra, a);          acks = {acks[6:0], a};
    for (int i = 0; i < v.nb; i++) begin
      db = (i < 4) ? v.data[31-8*i -: 8] : v.extra;
      wr_byte(db, a);
      acks = {acks[6:0], a};
      if (i == 3 && v.nb > 4) chk($sformatf("v%0d wr_en after word", idx), 32'(wr_cnt - w0), 32'd1);
    end
    i2c_stop;
    chk($sformatf("v%0d ack slots", idx), 32'(acks), 32'(v.exp_ack));
    chk($sformatf("v%0d wr_en count", idx), 32'(wr_cnt - w0), 32'(v.exp_wr));
    chk($sformatf("v%0d rd_req count", idx), 32'(rd_cnt - r0), 32'd0);
    chk($sformatf("v%0d busy seen", idx), 32'(busy_cyc > b0), 32'(v.exp_busy));
    chk($sformatf("v%0d busy after stop", idx), 32'(busy), 32'd0);
    chk($sformatf("v%0d sda driven", idx), 32'(drv_cyc > d0), 32'(v.exp_ack != 8'd0));
    if (v.exp_wr != 0) begin
      chk($sformatf("v%0d wr_addr", idx), 32'(wr_addr_seen), 32'(v.ra));
      chk($sformatf("v%0d wr_data", idx), wr_data_seen, v.data);
    end
  endtask

  task automatic run_read;
    int w0, r0;
    logic a;
    logic [7:0] b;
    logic [31:0] exp_word;
    exp_word = 32'hCAFEF00D;
    w0 = wr_cnt; r0 = rd_cnt;
    i2c_start;
    wr_byte(8'hA0, a); chk("rd dev_w ack", 32'(a), 32'd1);
    wr_byte(8'h34, a); chk("rd reg ack", 32'(a), 32'd1);
    i2c_start;
    wr_byte(8'hA1, a); chk("rd dev_r ack", 32'(a), 32'd1);
    for (int i = 0; i < 4; i++) begin
      rd_byte(i == 3, b);
      chk($sformatf("rd byte %0d", i), 32'(b), 32'(exp_word[31-8*i -: 8]));
    end
    chk("rd sda released after nack", 32'(sda_bus === 1'b0), 32'd0);
    chk("rd busy before stop", 32'(busy), 32'd1);
    i2c_stop;
    chk("rd busy after stop", 32'(busy), 32'd0);
    chk("rd rd_req count", 32'(rd_cnt - r0), 32'd1);
    chk("rd rd_addr", 32'(rd_addr_seen), 32'h34);
    chk("rd wr_en count", 32'(wr_cnt - w0), 32'd0);
  endtask

  task automatic run_reset_mid;
    int w0;
    logic a, rb;
    logic [7:0] bb;
    w0 = wr_cnt;
    bb = 8'hBE;
    i2c_start;
    wr_byte(8'hA0, a);
    wr_byte(8'h12, a);
    wr_byte(8'hDE, a);
    wr_byte(8'hAD, a);
    for (int i = 7; i >= 0; i--) bit_io(bb[i], rb);
    m_sda = 1'b1;
    #Q scl = 1'b1;
    #Q chk("rst ack slot driven", 32'(sda_bus === 1'b0), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst sda released", 32'(sda_bus === 1'b0), 32'd0);
    chk("rst strobes/busy", {29'd0, wr_en, rd_req, busy}, 32'd0);
    chk("rst addrs", {16'd0, wr_addr, rd_addr}, 32'd0);
    chk("rst wr_data", wr_data, 32'd0);
    #Q scl = 1'b0;
    #Q;
    @(negedge clk) rst_n = 1'b1;
    #Q;
    i2c_stop;
    chk("rst wr_en count", 32'(wr_cnt - w0), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{7'h50, 8'h12, 32'hDEADBEEF, 8'h00, 4, 8'h3F, 1, 1'b1};
    vecs[1] = '{7'h51, 8'h12, 32'hDEADBEEF, 8'h00, 4, 8'h00, 0, 1'b0};
    vecs[2] = '{7'h50, 8'h12, 32'hAABB0000, 8'h00, 2, 8'h0F, 0, 1'b1};
    vecs[3] = '{7'h50, 8'h05, 32'h11223344, 8'h00, 4, 8'h3F, 1, 1'b1};
    vecs[4] = '{7'h50, 8'h40, 32'h01020304, 8'h05, 5, 8'h7E, 1, 1'b1};
    rd_data = 32'hCAFEF00D;

    repeat (3) @(negedge clk);
    chk("reset strobes/busy", {29'd0, wr_en, rd_req, busy}, 32'd0);
    chk("reset addrs", {16'd0, wr_addr, rd_addr}, 32'd0);
    chk("reset wr_data", wr_data, 32'd0);
    chk("reset sda released", 32'(sda_bus === 1'b0), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 5; i++) run_write(vecs[i], i);
    run_read;
    run_reset_mid;
    run_write(vecs[0], 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
